// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the down_counter block.
package down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with one-shot / periodic modes and a registered
// terminal-count pulse.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic               tc_q, tc_d;
    logic [WIDTH-1:0]   start_val;
    logic               start_ok;

    // A same-cycle load feeds the start value directly, bypassing reload_q.
    assign start_val = (load && start) ? load_val : reload_q;
    assign start_ok  = start && (start_val != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = load ? load_val : reload_q;
        tc_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    count_d = start_val;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (en) begin
                    if (count_q == WIDTH'(1)) begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end else if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start_ok) begin
                    count_d = start_val;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, counter width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: load  input  1  write load_val into reload register.
REQ-005 SHALL have port: load_val  input  WIDTH  reload/start value.
REQ-006 SHALL have port: start  input  1  begin countdown from reload value.
REQ-007 SHALL have port: stop  input  1  abort countdown, return to IDLE.
REQ-008 SHALL have port: en  input  1  count enable; decrement only when high in RUN.
REQ-009 SHALL have port: auto_reload  input  1  1 = periodic mode, 0 = one-shot.
REQ-010 SHALL have port: count_out  output  WIDTH  current count, registered.
REQ-011 SHALL have port: tc  output  1  terminal-count pulse, registered, one cycle.
REQ-012 SHALL have port: busy  output  1  high while state is RUN.
REQ-013 SHALL have port: done  output  1  high while state is DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL write reload_q <= load_val on any cycle with load=1, in any state.
REQ-016 SHALL define start value = load_val when load and start are both high, else reload_q.
REQ-017 SHALL, in IDLE or DONE with start=1 and start value != 0, set count_out <= start value and go to RUN.
REQ-018 SHALL ignore start when start value == 0 (state, count_out, tc unchanged).
REQ-019 SHALL, in RUN with en=1 and count_out > 1, decrement count_out by 1.
REQ-020 SHALL, in RUN with en=1 and count_out == 1, assert tc for exactly the following cycle.
REQ-021 SHALL, on that terminal edge with auto_reload=1, set count_out <= reload_q and stay in RUN (period = reload_q enabled cycles; count_out never shows 0).
REQ-022 SHALL, on that terminal edge with auto_reload=0, set count_out <= 0 and go to DONE.
REQ-023 SHALL hold count_out in RUN when en=0.
REQ-024 SHALL, on stop=1 in RUN or DONE, go to IDLE holding count_out; stop has priority over decrement, terminal event, and start.
REQ-025 SHALL sample auto_reload only at the terminal edge; reload_q changes during RUN affect only the next reload.
REQ-026 SHALL keep tc low in every cycle not covered by REQ-020.
REQ-027 SHALL decode busy and done directly from the state register, with no added latency.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, set state IDLE, count_out 0, reload_q 0, tc 0; reset overrides every other input, including mid-RUN.
REQ-029 SHALL present busy=0 and done=0 during and after reset until start.

Structure
REQ-030 SHALL place the state enumeration (IDLE=0, RUN=1, DONE=2, 2-bit encoding) and the WIDTH default in shared package down_counter_pkg.
REQ-031 SHALL be a single module with no sub-module; FSM and datapath are in one file.

Verification
REQ-032 SHALL cover: reset=1 for 20 cycles -> count_out=0, tc=0, busy=0, done=0.
REQ-033 SHALL cover: load=1, load_val=5, start=1 same cycle, en=1, auto_reload=0 -> count_out 5,4,3,2,1,0; tc high one cycle with count_out=0; done=1, busy=0.
REQ-034 SHALL cover: load 3, start, auto_reload=1, en=1 continuous -> count_out 3,2,1,3,2,1,...; tc every 3rd cycle, busy stays 1.
REQ-035 SHALL cover: en low for 2 cycles at count_out=4 -> count_out holds 4, then resumes at 3.
REQ-036 SHALL cover: stop with en=1 at count_out=2 -> IDLE, count_out=2, tc=0; then start with reload_q=0 -> ignored.
REQ-037 SHALL cover: load 9, start, reset=1 at count_out=7 -> next edge count_out=0, IDLE, tc=0.
